// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Program-counter and fetch stage. Drives the word-indexed address port of the
// instruction memory, registers the returned word for decode and handles
// decode back-pressure (valid/ready), branch/jump redirect and HALT detection.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   imem_addr        current PC to instruction memory (combinational from PC reg)
//   imem_data        instruction word read back in the same cycle
//   dec_ready        decode accepts inst_out this cycle
//   redirect_en      branch/jump taken; load redirect_target
//   redirect_target  new PC (word index), reduced modulo MEM_DEPTH
//   inst_out         registered instruction for decode
//   pc_out           PC of inst_out
//   inst_valid       inst_out/pc_out hold an unconsumed instruction
//   halted           fetch has stopped on a HALT word
//   fetch_count      instructions captured since reset, saturating
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned    WL        = 32,
    parameter int unsigned    MEM_DEPTH = 256,
    parameter int unsigned    RESET_VEC = 0,
    parameter logic [WL-1:0]  HALT_WORD = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [WL-1:0] imem_addr,
    input  logic [WL-1:0] imem_data,
    input  logic          dec_ready,
    input  logic          redirect_en,
    input  logic [WL-1:0] redirect_target,
    output logic [WL-1:0] inst_out,
    output logic [WL-1:0] pc_out,
    output logic          inst_valid,
    output logic          halted,
    output logic [31:0]   fetch_count
);

    // MEM_DEPTH is a power of two, so modulo reduces to a mask.
    localparam logic [WL-1:0] PcMask  = WL'(MEM_DEPTH - 1);
    localparam logic [WL-1:0] PcReset = WL'(RESET_VEC);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } state_e;

    state_e        state_q, state_d;
    logic [WL-1:0] pc_q, pc_d;
    logic [WL-1:0] inst_q, inst_d;
    logic [WL-1:0] pc_out_q, pc_out_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic [31:0]   count_q, count_d;

    // Output slot is free, or its occupant is being drained this cycle.
    logic take;
    assign take = !valid_q || dec_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        count_d  = count_q;

        if (redirect_en) begin
            // Redirect beats everything, including a HALT word on imem_data,
            // and flushes the output slot even while decode is stalling.
            pc_d    = redirect_target & PcMask;
            valid_d = 1'b0;
            state_d = StRun;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (take) begin
                        inst_d   = imem_data;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 32'd1;
                        end
                        if (imem_data == HALT_WORD) begin
                            // PC stays on the HALT word so imem_addr points at it.
                            state_d = StHalt;
                        end else begin
                            pc_d = (pc_q + WL'(1)) & PcMask;
                        end
                    end
                end
                StHalt: begin
                    if (dec_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StBoot;
                end
            endcase
        end

        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StBoot;
            pc_q     <= PcReset;
            inst_q   <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign inst_out    = inst_q;
    assign pc_out      = pc_out_q;
    assign inst_valid  = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized stimulus,
// all checked every cycle against a transaction-level reference model.
module tb_fetch_unit;

    localparam int unsigned   DEPTH = 256;
    localparam logic [31:0]   HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        dec_ready = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [DEPTH];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    fetch_unit #(
        .WL        (32),
        .MEM_DEPTH (DEPTH),
        .RESET_VEC (0),
        .HALT_WORD (HALT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .dec_ready       (dec_ready),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .inst_out        (inst_out),
        .pc_out          (pc_out),
        .inst_valid      (inst_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_inst, m_pc_out, m_count;
    bit          m_valid, m_started, m_halted;

    function automatic void model_reset();
        m_pc      = 32'd0;
        m_inst    = 32'd0;
        m_pc_out  = 32'd0;
        m_count   = 32'd0;
        m_valid   = 1'b0;
        m_started = 1'b0;
        m_halted  = 1'b0;
    endfunction

    // Apply one clock edge worth of behaviour given the current inputs.
    function automatic void model_step();
        logic [31:0] word;
        if (redirect_en) begin
            m_pc      = redirect_target % DEPTH;
            m_valid   = 1'b0;
            m_started = 1'b1;
            m_halted  = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_halted) begin
            if (dec_ready) m_valid = 1'b0;
        end else if (!m_valid || dec_ready) begin
            word     = mem[m_pc];
            m_inst   = word;
            m_pc_out = m_pc;
            m_valid  = 1'b1;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (word == HALT) m_halted = 1'b1;
            else m_pc = (m_pc + 1) % DEPTH;
        end
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, ".addr"},  imem_addr,          m_pc);
        check_eq({tag, ".inst"},  inst_out,           m_inst);
        check_eq({tag, ".pcout"}, pc_out,             m_pc_out);
        check_eq({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, m_valid});
        check_eq({tag, ".halt"},  {31'd0, halted},     {31'd0, m_halted});
        check_eq({tag, ".count"}, fetch_count,        m_count);
    endtask

    // Inputs are set at posedge+1; model advances, then DUT is sampled at posedge+1.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input bit dr, input bit re, input logic [31:0] tgt);
        dec_ready       = dr;
        redirect_en     = re;
        redirect_target = tgt;
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq({tag, ".async_valid"}, {31'd0, inst_valid}, 32'd0);
        check_eq({tag, ".async_count"}, fetch_count, 32'd0);
        check_eq({tag, ".async_addr"},  imem_addr, 32'd0);
        compare_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        mem[3] = 32'h44; mem[4] = 32'h55; mem[5] = HALT;
        mem[8'h40] = 32'hCAFE_0040;

        model_reset();
        #3;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Boot cycle then three consecutive fetches.
        drive(1, 0, 0);
        step("boot");
        check_eq("boot.valid", {31'd0, inst_valid}, 32'd0);
        step("f0");
        check_eq("f0.inst", inst_out, 32'h11);
        step("f1");
        check_eq("f1.inst", inst_out, 32'h22);

        // Stall on 0x22 for three cycles.
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check_eq("stall.inst", inst_out, 32'h22);
        end
        drive(1, 0, 0);
        step("resume");
        check_eq("resume.inst", inst_out, 32'h33);
        check_eq("resume.count", fetch_count, 32'd3);

        // Redirect during a stall flushes the slot.
        drive(0, 0, 0);
        step("stall2");
        drive(0, 1, 32'h40);
        step("redir");
        check_eq("redir.addr", imem_addr, 32'h40);
        drive(1, 0, 0);
        step("redir_cap");
        check_eq("redir_cap.inst", inst_out, 32'hCAFE_0040);
        check_eq("redir_cap.pc", pc_out, 32'h40);

        // Run into the HALT word at address 5.
        drive(1, 1, 3);
        step("to3");
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) step("pre_halt");
        check_eq("halt.inst", inst_out, HALT);
        check_eq("halt.pc", pc_out, 32'd5);
        check_eq("halt.flag", {31'd0, halted}, 32'd1);
        check_eq("halt.addr", imem_addr, 32'd5);
        drive(0, 0, 0);
        step("halt_hold");
        drive(1, 0, 0);
        step("halt_drain");
        check_eq("halt_drain.valid", {31'd0, inst_valid}, 32'd0);
        check_eq("halt_drain.addr", imem_addr, 32'd5);
        drive(1, 1, 0);
        step("unhalt");
        check_eq("unhalt.flag", {31'd0, halted}, 32'd0);

        // Wrap at the top of memory and modulo-reduce a wide target.
        drive(1, 1, DEPTH - 1);
        step("to_top");
        drive(1, 0, 0);
        step("wrap");
        check_eq("wrap.addr", imem_addr, 32'd0);
        drive(1, 1, 32'h0001_0003);
        step("wide_tgt");
        check_eq("wide_tgt.addr", imem_addr, 32'd3);
        drive(1, 0, 0);
        step("post_wide");

        // Async reset with a valid instruction in the slot.
        mid_reset("midrst");

        // Randomized phase.
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 7,
                  $urandom_range(0, 11) == 0,
                  ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 499) == 0) mid_reset("rnd_rst");
            else step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
